// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF   = 32;
  localparam int DW_DEF   = 32;
  localparam int STREAK_W = 4;
  localparam int WE_W     = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  // Which port owns the response that the memory returns next cycle.
  function automatic owner_e owner_of(input logic i_gnt, input logic d_gnt);
    owner_e own;
    if (i_gnt) begin
      own = OWN_I;
    end else if (d_gnt) begin
      own = OWN_D;
    end else begin
      own = OWN_NONE;
    end
    return own;
  endfunction

endpackage

// File: rtl/mem_arb_streak_cnt.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module mem_arb_streak_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [STREAK_W-1:0] MAX_V = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] count_r;
  logic [STREAK_W-1:0] count_nxt_s;

  // Next count: clear wins, increments stop at the limit.
  always_comb begin
    count_nxt_s = count_r;
    if (clr) begin
      count_nxt_s = {STREAK_W{1'b0}};
    end else if (inc && (count_r != MAX_V)) begin
      count_nxt_s = count_r + {{(STREAK_W-1){1'b0}}, 1'b1};
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Streak count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {STREAK_W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign sat = (count_r == MAX_V);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one synchronous-read memory between the fetch and load/store ports;
// data has priority, the streak counter bounds how long fetch can be starved.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DW-1:0]     i_rdata,
  input  logic              d_req,
  input  logic [AW-1:0]     d_addr,
  input  logic [WE_W-1:0]   d_we,
  input  logic [DW-1:0]     d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DW-1:0]     d_rdata,
  output logic              mem_en,
  output logic [AW-1:0]     mem_addr,
  output logic [WE_W-1:0]   mem_we,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  logic   i_gnt_s;
  logic   d_gnt_s;
  logic   sat_s;
  logic   inc_s;
  logic   clr_s;
  owner_e owner_r;

  mem_arb_streak_cnt #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_streak (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_s),
    .clr   (clr_s),
    .sat   (sat_s)
  );

  // Grant decision; gated by reset so nothing is granted while it is held low.
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (!reset) begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (i_req && d_req) begin
      i_gnt_s = sat_s;
      d_gnt_s = !sat_s;
    end else begin
      i_gnt_s = i_req;
      d_gnt_s = d_req;
    end
    inc_s = d_gnt_s & i_req;
    clr_s = i_gnt_s | !i_req;
  end

  // Memory request mux; an idle cycle drives all-zero so the bus is quiet.
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_we    = {WE_W{1'b0}};
    mem_wdata = {DW{1'b0}};
    case ({i_gnt_s, d_gnt_s})
      2'b10: begin
        mem_en   = 1'b1;
        mem_addr = i_addr;
      end
      2'b01: begin
        mem_en    = 1'b1;
        mem_addr  = d_addr;
        mem_we    = d_we;
        mem_wdata = d_wdata;
      end
      default: begin
        mem_en    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_we    = {WE_W{1'b0}};
        mem_wdata = {DW{1'b0}};
      end
    endcase
  end

  // Response owner: remembers who was granted so the read data is routed back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r <= OWN_NONE;
    end else begin
      owner_r <= owner_of(i_gnt_s, d_gnt_s);
    end
  end

  assign i_gnt    = i_gnt_s;
  assign d_gnt    = d_gnt_s;
  assign i_rvalid = (owner_r == OWN_I);
  assign d_rvalid = (owner_r == OWN_D);
  assign i_rdata  = i_rvalid ? mem_rdata : {DW{1'b0}};
  assign d_rdata  = d_rvalid ? mem_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter with a byte-enabled memory model.
module tb_unified_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_we;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] mem_model [0:255];

  function automatic logic [31:0] preload_word(input logic [31:0] addr);
    return 32'hA500_0000 | {24'h00_0000, addr[9:2]};
  endfunction

  // Synchronous-read memory: old word is returned, byte lanes written at the edge.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem_model[mem_addr[9:2]];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem_model[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        chk_data;
  } resp_t;

  resp_t i_q[$];
  resp_t d_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_resp(input string tag);
    resp_t r;
    if (i_q.size() != 0 && i_q[0].cyc + 1 == cyc) begin
      r = i_q.pop_front();
      check_eq({tag, "_i_rvalid"}, {31'd0, i_rvalid}, 32'd1);
      if (i_rvalid) check_eq({tag, "_i_rdata"}, i_rdata, r.data);
    end else begin
      check_eq({tag, "_i_rvalid"}, {31'd0, i_rvalid}, 32'd0);
    end
    if (d_q.size() != 0 && d_q[0].cyc + 1 == cyc) begin
      r = d_q.pop_front();
      check_eq({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 32'd1);
      if (d_rvalid && r.chk_data) check_eq({tag, "_d_rdata"}, d_rdata, r.data);
    end else begin
      check_eq({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
    end
  endtask

  task automatic step(input string tag, input logic ei, input logic ed,
                      input logic [31:0] d_exp, input logic d_chk);
    logic [31:0] exp_addr;
    @(negedge clk);
    cyc++;
    check_resp(tag);
    check_eq({tag, "_i_gnt"}, {31'd0, i_gnt}, {31'd0, ei});
    check_eq({tag, "_d_gnt"}, {31'd0, d_gnt}, {31'd0, ed});
    check_eq({tag, "_mem_en"}, {31'd0, mem_en}, {31'd0, (ei | ed)});
    exp_addr = ei ? i_addr : (ed ? d_addr : 32'd0);
    check_eq({tag, "_mem_addr"}, mem_addr, exp_addr);
    check_eq({tag, "_mem_we"}, {28'd0, mem_we}, ed ? {28'd0, d_we} : 32'd0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, ed ? d_wdata : 32'd0);
    if (ei) i_q.push_back('{cyc, preload_word(i_addr), 1'b1});
    if (ed) d_q.push_back('{cyc, d_exp, d_chk});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ei;
    logic ed;
    for (int i = 0; i < 256; i++) mem_model[i] = preload_word(32'(i) << 2);
    mem_rdata = 32'hDEAD_BEEF;
    reset   = 1'b0;
    i_req   = 1'b0;
    i_addr  = 32'h0;
    d_req   = 1'b1;
    d_addr  = 32'h40;
    d_we    = 4'b0000;
    d_wdata = 32'h0;

    // reset held with a pending data request: everything quiet
    step("rst", 1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("rst_i_rdata", i_rdata, 32'h0);
    check_eq("rst_d_rdata", d_rdata, 32'h0);
    reset = 1'b1;
    step("rel", 1'b0, 1'b1, preload_word(32'h40), 1'b1);
    d_req = 1'b0;
    step("rel_resp", 1'b0, 1'b0, 32'h0, 1'b0);

    // fetch only, three consecutive words
    i_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_addr = 32'(4 * k);
      step("fetch", 1'b1, 1'b0, 32'h0, 1'b0);
    end
    i_req = 1'b0;
    step("fetch_end", 1'b0, 1'b0, 32'h0, 1'b0);

    // both requesting: D,D,D,D,I repeated
    i_req  = 1'b1;
    d_req  = 1'b1;
    i_addr = 32'h20;
    d_addr = 32'h80;
    for (int k = 0; k < 10; k++) begin
      ed = ((k % 5) != 4);
      ei = !ed;
      step("arb", ei, ed, preload_word(d_addr), 1'b1);
      if (ei) i_addr = i_addr + 32'd4;
      else    d_addr = d_addr + 32'd4;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    step("arb_end", 1'b0, 1'b0, 32'h0, 1'b0);

    // partial store then load of the same word
    d_req   = 1'b1;
    d_addr  = 32'h102;
    d_we    = 4'b0011;
    d_wdata = 32'h0000_BEEF;
    step("store", 1'b0, 1'b1, 32'h0, 1'b0);
    d_addr  = 32'h100;
    d_we    = 4'b0000;
    d_wdata = 32'h0;
    step("load", 1'b0, 1'b1, 32'hA500_BEEF, 1'b1);
    d_req = 1'b0;
    step("load_end", 1'b0, 1'b0, 32'h0, 1'b0);

    // reset during the response cycle drops the response
    d_req  = 1'b1;
    d_addr = 32'h44;
    step("rmid", 1'b0, 1'b1, preload_word(32'h44), 1'b1);
    reset = 1'b0;
    d_req = 1'b0;
    d_q.delete();
    step("rmid_rst", 1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) step("rmid_post", 1'b0, 1'b0, 32'h0, 1'b0);

    // pulsed data traffic without fetch must not build up a streak
    d_addr = 32'h60;
    for (int k = 0; k < 20; k++) begin
      d_req = ((k % 2) == 0);
      step("pulse", 1'b0, d_req, preload_word(32'h60), 1'b1);
    end
    i_req  = 1'b1;
    d_req  = 1'b1;
    i_addr = 32'h0;
    for (int k = 0; k < 5; k++) begin
      ed = (k < MAXS);
      ei = !ed;
      step("post_pulse", ei, ed, preload_word(d_addr), 1'b1);
      if (ed) d_addr = d_addr + 32'd4;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < 2; k++) step("drain", 1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("i_q_left", i_q.size(), 32'd0);
    check_eq("d_q_left", d_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
